// File: rtl/fft_addr_ctrl_if.sv
// Host/memory-side bus of the FFT address controller: sample stream in, memory control out.
interface fft_addr_ctrl_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 5
);
  localparam int SW = $clog2(ADDR_WIDTH) + 1;

  logic                  start;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_real;
  logic [DATA_WIDTH-1:0] in_imag;
  logic                  roW;
  logic                  singlewrite;
  logic [ADDR_WIDTH-1:0] A_addr;
  logic [ADDR_WIDTH-1:0] B_addr;
  logic [DATA_WIDTH-1:0] A_real_in;
  logic [DATA_WIDTH-1:0] A_imag_in;
  logic [ADDR_WIDTH-2:0] tw_idx;
  logic                  bf_go;
  logic                  busy;
  logic                  done;
  logic [SW-1:0]         stage;

  modport master (
    output start, in_valid, in_real, in_imag,
    input  in_ready, roW, singlewrite, A_addr, B_addr, A_real_in, A_imag_in,
           tw_idx, bf_go, busy, done, stage
  );

  modport slave (
    input  start, in_valid, in_real, in_imag,
    output in_ready, roW, singlewrite, A_addr, B_addr, A_real_in, A_imag_in,
           tw_idx, bf_go, busy, done, stage
  );
endinterface

// File: rtl/fft_addr_ctrl.sv
// Load and in-place radix-2 DIT butterfly address sequencer for the FFT memory.
// Optional macro FFT_BITREV_LOAD_EN: bit-reversed load addresses (natural-order output).
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | accepting N samples, writing port A
// RD    | butterfly operand read, addresses presented
// WT    | butterfly latency, bf_go in first cycle
// WR    | butterfly result write-back on both ports
// DONE  | one-cycle completion pulse
module fft_addr_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 5,
  parameter int BFLY_LAT   = 2
) (
  input  logic           clk,
  input  logic           rst,
  fft_addr_ctrl_if.slave bus
);
  localparam int AW = ADDR_WIDTH;
  localparam int TW = ADDR_WIDTH - 1;
  localparam int SW = $clog2(ADDR_WIDTH) + 1;
  localparam int LW = (BFLY_LAT > 1) ? $clog2(BFLY_LAT) : 1;
  localparam logic [TW-1:0] J_LAST   = '1;
  localparam logic [AW-1:0] CNT_LAST = '1;
  localparam logic [SW-1:0] S_LAST   = SW'(AW - 1);
  localparam logic [LW-1:0] LAT_INIT = LW'(BFLY_LAT - 1);

  typedef enum logic [2:0] {IDLE, LOAD, RD, WT, WR, DONE} state_t;

  state_t        state_q;
  logic [AW-1:0] cnt_q;
  logic [SW-1:0] s_q;
  logic [TW-1:0] j_q;
  logic [LW-1:0] lat_q;
  logic          row_q, in_ready_q, bf_go_q, busy_q, done_q;
  logic [AW-1:0] a_addr_q, b_addr_q;
  logic [TW-1:0] tw_q;

  function automatic logic [AW-1:0] load_addr(input logic [AW-1:0] i);
    logic [AW-1:0] r;
`ifdef FFT_BITREV_LOAD_EN
    for (int k = 0; k < AW; k++) r[k] = i[AW-1-k];
`else
    r = i;
`endif
    return r;
  endfunction

  function automatic logic [AW-1:0] bfly_a(input logic [SW-1:0] s, input logic [TW-1:0] j);
    logic [AW-1:0] jw, mask;
    jw   = {1'b0, j};
    mask = (AW'(1) << s) - AW'(1);
    return ((jw >> s) << (s + SW'(1))) | (jw & mask);
  endfunction

  // bit s of A is always clear, so B = A + half never carries
  function automatic logic [AW-1:0] bfly_b(input logic [SW-1:0] s, input logic [TW-1:0] j);
    return bfly_a(s, j) | (AW'(1) << s);
  endfunction

  function automatic logic [TW-1:0] bfly_tw(input logic [SW-1:0] s, input logic [TW-1:0] j);
    logic [TW-1:0] mask;
    mask = (TW'(1) << s) - TW'(1);
    return (j & mask) << (SW'(TW) - s);
  endfunction

  logic in_load, in_comp;
  assign in_load = (state_q == LOAD);
  assign in_comp = (state_q == RD) || (state_q == WT) || (state_q == WR);

  // writes are suppressed in the reset cycle so memory is never partially updated
  assign bus.roW         = (in_load ? bus.in_valid : row_q) & ~rst;
  assign bus.singlewrite = in_load & bus.in_valid & ~rst;
  assign bus.in_ready    = in_ready_q;
  assign bus.A_addr      = a_addr_q;
  assign bus.B_addr      = b_addr_q;
  assign bus.A_real_in   = bus.in_real;
  assign bus.A_imag_in   = bus.in_imag;
  assign bus.tw_idx      = tw_q;
  assign bus.bf_go       = bf_go_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.stage       = in_comp ? s_q : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      s_q        <= '0;
      j_q        <= '0;
      lat_q      <= '0;
      row_q      <= 1'b0;
      in_ready_q <= 1'b0;
      bf_go_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      a_addr_q   <= '0;
      b_addr_q   <= '0;
      tw_q       <= '0;
    end else begin
      bf_go_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        IDLE: if (bus.start) begin
          state_q    <= LOAD;
          cnt_q      <= '0;
          in_ready_q <= 1'b1;
          busy_q     <= 1'b1;
          a_addr_q   <= load_addr('0);
        end
        LOAD: if (bus.in_valid) begin
          if (cnt_q == CNT_LAST) begin
            state_q    <= RD;
            in_ready_q <= 1'b0;
            s_q        <= '0;
            j_q        <= '0;
            a_addr_q   <= bfly_a('0, '0);
            b_addr_q   <= bfly_b('0, '0);
            tw_q       <= bfly_tw('0, '0);
          end else begin
            cnt_q    <= cnt_q + 1'b1;
            a_addr_q <= load_addr(cnt_q + 1'b1);
          end
        end
        RD: begin
          state_q <= WT;
          bf_go_q <= 1'b1;
          lat_q   <= LAT_INIT;
        end
        WT: begin
          if (lat_q == '0) begin
            state_q <= WR;
            row_q   <= 1'b1;
          end else begin
            lat_q <= lat_q - 1'b1;
          end
        end
        WR: begin
          row_q <= 1'b0;
          if (j_q != J_LAST) begin
            state_q  <= RD;
            j_q      <= j_q + 1'b1;
            a_addr_q <= bfly_a(s_q, j_q + 1'b1);
            b_addr_q <= bfly_b(s_q, j_q + 1'b1);
            tw_q     <= bfly_tw(s_q, j_q + 1'b1);
          end else if (s_q != S_LAST) begin
            state_q  <= RD;
            s_q      <= s_q + 1'b1;
            j_q      <= '0;
            a_addr_q <= bfly_a(s_q + 1'b1, '0);
            b_addr_q <= bfly_b(s_q + 1'b1, '0);
            tw_q     <= bfly_tw(s_q + 1'b1, '0);
          end else begin
            state_q  <= DONE;
            done_q   <= 1'b1;
            s_q      <= '0;
            j_q      <= '0;
            a_addr_q <= '0;
            b_addr_q <= '0;
            tw_q     <= '0;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fft_addr_ctrl.sv
// Scoreboard bench for fft_addr_ctrl: load, butterfly addressing, completion and reset.
`timescale 1ns/1ps
module tb_fft_addr_ctrl;
  localparam int DW = 16;
  localparam int AW = 5;
  localparam int TW = AW - 1;
  localparam int BL = 2;
  localparam int N  = 1 << AW;
  localparam int SW = $clog2(AW) + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fft_addr_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  fft_addr_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BFLY_LAT(BL)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic          row;
    logic          sw;
    logic          bf_go;
    logic          busy;
    logic          done;
    logic          in_ready;
    logic [AW-1:0] a;
    logic [AW-1:0] b;
    logic [TW-1:0] tw;
    logic [SW-1:0] stage;
  } obs_t;

  obs_t exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  function automatic obs_t sample_obs();
    obs_t o;
    o.row      = bus.roW;
    o.sw       = bus.singlewrite;
    o.bf_go    = bus.bf_go;
    o.busy     = bus.busy;
    o.done     = bus.done;
    o.in_ready = bus.in_ready;
    o.a        = bus.A_addr;
    o.b        = bus.B_addr;
    o.tw       = bus.tw_idx;
    o.stage    = bus.stage;
    return o;
  endfunction

  function automatic obs_t mk(input bit row, input bit sw, input bit bf, input bit busy,
                              input bit done, input bit rdy, input int a, input int b,
                              input int tw, input int st);
    obs_t e;
    e.row = row; e.sw = sw; e.bf_go = bf; e.busy = busy; e.done = done; e.in_ready = rdy;
    e.a = AW'(a); e.b = AW'(b); e.tw = TW'(tw); e.stage = SW'(st);
    return e;
  endfunction

  function automatic int ref_load_addr(input int i);
    int r;
`ifdef FFT_BITREV_LOAD_EN
    r = 0;
    for (int k = 0; k < AW; k++) if ((i >> k) & 1) r = r | (1 << (AW - 1 - k));
`else
    r = i;
`endif
    return r;
  endfunction

  task automatic test_reset();
    obs_t o, e;
    rst = 1'b1; bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_real = '0; bus.in_imag = '0;
    repeat (2) @(posedge clk);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); rst = 1'b0; bus.start = 1'b0;
      exp_q.push_back('0);
      #1; o = sample_obs(); e = exp_q.pop_front();
      n_checks++;
      if (o !== e) $display("FAIL reset_idle cyc=%0d got=%h exp=%h", c, o, e); else n_pass++;
    end
    // rst and start together: rst must win
    @(negedge clk); rst = 1'b1; bus.start = 1'b1;
    @(negedge clk); rst = 1'b0; bus.start = 1'b0;
    exp_q.push_back('0);
    #1; o = sample_obs(); e = exp_q.pop_front();
    n_checks++;
    if (o !== e) $display("FAIL rst_beats_start got=%h exp=%h", o, e); else n_pass++;
  endtask

  task automatic test_load();
    obs_t o, e;
    int cnt = 0;
    int cyc = 0;
    bit v;
    logic [DW-1:0] r, im;
    @(negedge clk); bus.start = 1'b1; bus.in_valid = 1'b0;
    while (cnt < N && cyc < 200) begin
      @(negedge clk);
      bus.start = 1'b0;
      v = !(cyc == 1 || cyc == 9 || cyc == 10);
      r = DW'($urandom); im = DW'($urandom);
      bus.in_valid = v; bus.in_real = r; bus.in_imag = im;
      exp_q.push_back(mk(v, v, 0, 1, 0, 1, ref_load_addr(cnt), 0, 0, 0));
      #1; o = sample_obs(); e = exp_q.pop_front();
      n_checks++;
      if (o !== e) $display("FAIL load cyc=%0d cnt=%0d got=%h exp=%h", cyc, cnt, o, e);
      else n_pass++;
      n_checks++;
      if ({bus.A_real_in, bus.A_imag_in} !== {r, im})
        $display("FAIL load_data cyc=%0d got=%h exp=%h", cyc, {bus.A_real_in, bus.A_imag_in}, {r, im});
      else n_pass++;
      if (v) cnt++;
      cyc++;
    end
    n_checks++;
    if (cnt != N) $display("FAIL load_timeout beats=%0d exp=%0d", cnt, N); else n_pass++;
  endtask

  task automatic test_compute();
    obs_t o, e;
    int half, a, b, tw;
    int cyc = 0;
    for (int s = 0; s < AW; s++) begin
      half = 1 << s;
      for (int g = 0; g < N / (2 * half); g++)
        for (int p = 0; p < half; p++) begin
          a  = g * 2 * half + p;
          b  = a + half;
          tw = p * ((N / 2) / half);
          for (int k = 0; k < BL + 2; k++)
            exp_q.push_back(mk(k == BL + 1, 0, k == 1, 1, 0, 0, a, b, tw, s));
        end
    end
    while (exp_q.size() > 0) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.start = (cyc == 37);
      #1; o = sample_obs(); e = exp_q.pop_front();
      n_checks++;
      if (o !== e) $display("FAIL compute cyc=%0d got=%h exp=%h", cyc, o, e); else n_pass++;
      cyc++;
    end
    @(negedge clk); bus.start = 1'b0;
    #1;
    n_checks++;
    if ({bus.done, bus.busy, bus.roW, bus.bf_go} !== 4'b1100)
      $display("FAIL done_pulse got=%b exp=1100", {bus.done, bus.busy, bus.roW, bus.bf_go});
    else n_pass++;
    @(negedge clk);
    exp_q.push_back('0);
    #1; o = sample_obs(); e = exp_q.pop_front();
    n_checks++;
    if (o !== e) $display("FAIL after_done got=%h exp=%h", o, e); else n_pass++;
  endtask

  task automatic test_completion();
    int done_at = -1;
    @(negedge clk); bus.start = 1'b1; bus.in_valid = 1'b0;
    for (int k = 0; k < 1000 && done_at < 0; k++) begin
      @(negedge clk);
      bus.start = (k == 100);
      bus.in_valid = 1'b1;
      #1;
      if (bus.done === 1'b1) done_at = k;
    end
    n_checks++;
    if (done_at != N + AW * (N / 2) * (BL + 2))
      $display("FAIL done_latency got=%0d exp=%0d", done_at, N + AW * (N / 2) * (BL + 2));
    else n_pass++;
    @(negedge clk); bus.start = 1'b0; bus.in_valid = 1'b0;
    #1;
    n_checks++;
    if ({bus.done, bus.busy, bus.in_ready} !== 3'b000)
      $display("FAIL done_one_cycle got=%b exp=000", {bus.done, bus.busy, bus.in_ready});
    else n_pass++;
  endtask

  task automatic test_midrun_reset();
    obs_t o, e;
    bit found = 1'b0;
    @(negedge clk); bus.start = 1'b1; bus.in_valid = 1'b0;
    for (int k = 0; k < 2000 && !found; k++) begin
      @(negedge clk);
      bus.start = 1'b0; bus.in_valid = 1'b1;
      #1;
      if (bus.stage === SW'(2) && bus.bf_go === 1'b1) found = 1'b1;
    end
    n_checks++;
    if (!found) $display("FAIL wait_pass2_timeout got=0 exp=1"); else n_pass++;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({bus.roW, bus.busy} !== 2'b01)
      $display("FAIL rst_in_wt got=%b exp=01", {bus.roW, bus.busy});
    else n_pass++;
    @(negedge clk); rst = 1'b0; bus.in_valid = 1'b0;
    exp_q.push_back('0);
    #1; o = sample_obs(); e = exp_q.pop_front();
    n_checks++;
    if (o !== e) $display("FAIL idle_after_rst got=%h exp=%h", o, e); else n_pass++;
    @(negedge clk); bus.start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.start = 1'b0; bus.in_valid = 1'b1;
      exp_q.push_back(mk(1, 1, 0, 1, 0, 1, ref_load_addr(i), 0, 0, 0));
      #1; o = sample_obs(); e = exp_q.pop_front();
      n_checks++;
      if (o !== e) $display("FAIL reload beat=%0d got=%h exp=%h", i, o, e); else n_pass++;
    end
    @(negedge clk); rst = 1'b1; bus.in_valid = 1'b1;
    #1;
    n_checks++;
    if ({bus.roW, bus.singlewrite} !== 2'b00)
      $display("FAIL rst_load_write got=%b exp=00", {bus.roW, bus.singlewrite});
    else n_pass++;
    @(negedge clk); rst = 1'b0; bus.in_valid = 1'b0;
    exp_q.push_back('0);
    #1; o = sample_obs(); e = exp_q.pop_front();
    n_checks++;
    if (o !== e) $display("FAIL idle_after_load_rst got=%h exp=%h", o, e); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_load();
    test_compute();
    test_completion();
    test_midrun_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
